// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage MIPS core: stall/bubble and bypass selects from decode Tuse/Tnew tags.
// Latency: stall and forwarding selects are combinational from the current E/M/W state and the D inputs.
// Backpressure: stall holds PC and F/D and bubbles E; M and W always drain.
module hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int T_W   = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic [T_W-1:0]   d_rsuse,
    input  logic [T_W-1:0]   d_rtuse,
    input  logic [REG_W-1:0] d_tarreg,
    input  logic [T_W-1:0]   d_tnew,
    output logic             stall,
    output logic [1:0]       d_fwd_rs,
    output logic [1:0]       d_fwd_rt,
    output logic [1:0]       e_fwd_rs,
    output logic [1:0]       e_fwd_rt,
    output logic             m_fwd_rt,
    output logic [CNT_W-1:0] stall_cnt
);

    // Per-stage destination and remaining cycles until the result exists.
    logic [REG_W-1:0] tar_e, tar_m, tar_w;
    logic [T_W-1:0]   tnew_e, tnew_m, tnew_w;
    logic [REG_W-1:0] rs_e, rt_e;
    // Only rt is consumed in M (store data), so rs is not carried past E.
    logic [REG_W-1:0] rt_m;

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
        return (x == '0) ? '0 : x - T_W'(1);
    endfunction

    function automatic logic stall_hit(
        input logic [REG_W-1:0] r,
        input logic [T_W-1:0]   use_t,
        input logic [REG_W-1:0] tar,
        input logic [T_W-1:0]   tnew
    );
        return (r == tar) && (tar != '0) && (tnew > use_t);
    endfunction

    // First matching writer wins; a match whose result is not ready yet
    // blocks older writers and selects the register file.
    function automatic logic [1:0] d_sel(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] te, input logic [T_W-1:0] ne,
        input logic [REG_W-1:0] tm, input logic [T_W-1:0] nm,
        input logic [REG_W-1:0] tw, input logic [T_W-1:0] nw
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (r == '0)
            sel = 2'd0;
        else if (te == r)
            sel = (ne == '0) ? 2'd1 : 2'd0;
        else if (tm == r)
            sel = (nm == '0) ? 2'd2 : 2'd0;
        else if (tw == r)
            sel = (nw == '0) ? 2'd3 : 2'd0;
        return sel;
    endfunction

    function automatic logic [1:0] e_sel(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] tm, input logic [T_W-1:0] nm,
        input logic [REG_W-1:0] tw, input logic [T_W-1:0] nw
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (r == '0)
            sel = 2'd0;
        else if (tm == r)
            sel = (nm == '0) ? 2'd2 : 2'd0;
        else if (tw == r)
            sel = (nw == '0) ? 2'd3 : 2'd0;
        return sel;
    endfunction

    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            stall = stall_hit(d_rs, d_rsuse, tar_e, tnew_e)
                  | stall_hit(d_rt, d_rtuse, tar_e, tnew_e)
                  | stall_hit(d_rs, d_rsuse, tar_m, tnew_m)
                  | stall_hit(d_rt, d_rtuse, tar_m, tnew_m);
        end
    end

    always_comb begin
        d_fwd_rs = d_sel(d_rs, tar_e, tnew_e, tar_m, tnew_m, tar_w, tnew_w);
        d_fwd_rt = d_sel(d_rt, tar_e, tnew_e, tar_m, tnew_m, tar_w, tnew_w);
        e_fwd_rs = e_sel(rs_e, tar_m, tnew_m, tar_w, tnew_w);
        e_fwd_rt = e_sel(rt_e, tar_m, tnew_m, tar_w, tnew_w);
        m_fwd_rt = (rt_m == tar_w) && (tar_w != '0) && (tnew_w == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tar_e  <= '0;
            tnew_e <= '0;
            rs_e   <= '0;
            rt_e   <= '0;
            tar_m  <= '0;
            tnew_m <= '0;
            rt_m   <= '0;
            tar_w  <= '0;
            tnew_w <= '0;
        end else begin
            tar_w  <= tar_m;
            tnew_w <= sat_dec(tnew_m);
            tar_m  <= tar_e;
            tnew_m <= sat_dec(tnew_e);
            rt_m   <= rt_e;
            if (stall) begin
                tar_e  <= '0;
                tnew_e <= '0;
                rs_e   <= '0;
                rt_e   <= '0;
            end else begin
                tar_e  <= d_tarreg;
                tnew_e <= sat_dec(d_tnew);
                rs_e   <= d_rs;
                rt_e   <= d_rt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule
